// File: rtl/key_event_queue.sv
// rtl/key_event_queue.sv - IR key code FIFO drained one entry per game tick; optional KEY_DEDUP_EN drops repeats within a tick
`timescale 1ns/1ps
module key_event_queue #(
  parameter int CODE_W   = 4,
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 355551
) (
  input  logic                       master_clk,
  input  logic                       reset,
  input  logic                       code_valid,
  input  logic [CODE_W-1:0]          code,
  output logic                       tick,
  output logic [2:0]                 direction,
  output logic                       shoot,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [2:0]       DIR_LEFT  = 3'b001;
  localparam logic [2:0]       DIR_RIGHT = 3'b010;
  localparam logic [2:0]       DIR_STOP  = 3'b100;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [2:0]        dir_q;
  logic              shoot_q;
  logic              tick_c, pop, push, drop, dup;
  logic [CODE_W-1:0] head;

  assign tick_c = (div_q == DIV_LAST);
  assign head   = mem_q[rd_ptr_q];
  // count_q is sampled before this cycle's push, so a code written into an
  // empty queue on a tick cycle is never popped in that same cycle.
  assign pop    = tick_c && (count_q != '0);
  assign push   = code_valid && !dup && ((count_q != CNT_FULL) || pop);
  assign drop   = code_valid && !dup && (count_q == CNT_FULL) && !pop;

`ifdef KEY_DEDUP_EN
  logic              last_valid_q;
  logic [CODE_W-1:0] last_code_q;

  // A tick cycle starts a fresh dedup window, so it never counts as a repeat.
  assign dup = code_valid && last_valid_q && (code == last_code_q) && !tick_c;

  // Remember the last accepted code until the next tick
  always_ff @(posedge master_clk) begin
    if (reset) begin
      last_valid_q <= 1'b0;
      last_code_q  <= '0;
    end else if (tick_c || push) begin
      last_valid_q <= push;
      if (push) last_code_q <= code;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Next-state for tick divider, pointers, occupancy and sticky overflow
  always_comb begin
    div_d      = tick_c ? '0 : div_q + DIV_W'(1);
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q | drop;
  end

  // Control registers with synchronous reset
  always_ff @(posedge master_clk) begin
    if (reset) begin
      div_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage write; reset blocks the write so it wins over code_valid
  always_ff @(posedge master_clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= code;
  end

  // Decode the popped code once per tick; outputs hold for a full tick period
  always_ff @(posedge master_clk) begin
    if (reset) begin
      dir_q   <= DIR_STOP;
      shoot_q <= 1'b0;
    end else if (tick_c) begin
      shoot_q <= 1'b0;
      if (pop) begin
        case (head)
          CODE_W'(4'h4): dir_q <= DIR_LEFT;
          CODE_W'(4'h6): dir_q <= DIR_RIGHT;
          CODE_W'(4'h2): dir_q <= DIR_STOP;
          CODE_W'(4'h5): begin
            dir_q   <= DIR_STOP;
            shoot_q <= 1'b1;
          end
          default: dir_q <= dir_q;
        endcase
      end
    end
  end

  assign tick      = tick_c;
  assign direction = dir_q;
  assign shoot     = shoot_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// tb/tb_key_event_queue.sv - directed scoreboard bench for key_event_queue
`timescale 1ns/1ps
module tb_key_event_queue;

  localparam int CODE_W   = 4;
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;

  logic       master_clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [3:0] code;
  logic       tick;
  logic [2:0] direction;
  logic       shoot;
  logic [2:0] count;
  logic       overflow;

  typedef struct packed {
    logic [2:0] dir;
    logic       shoot;
  } exp_t;

  exp_t       sb[$];
  int         n_total = 0;
  int         n_pass  = 0;
  int         phase;
  logic [2:0] cur_dir, push_dir;
  logic       cur_shoot, ovf_e;
`ifdef KEY_DEDUP_EN
  logic       last_v;
  logic [3:0] last_c;
`endif

  key_event_queue #(.CODE_W(CODE_W), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .master_clk (master_clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code       (code),
    .tick       (tick),
    .direction  (direction),
    .shoot      (shoot),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 master_clk = ~master_clk;

  function automatic exp_t decode(input logic [3:0] c, input logic [2:0] prev);
    exp_t e;
    e.dir   = prev;
    e.shoot = 1'b0;
    case (c)
      4'h4: e.dir = 3'b001;
      4'h6: e.dir = 3'b010;
      4'h2: e.dir = 3'b100;
      4'h5: begin e.dir = 3'b100; e.shoot = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset(input logic cv, input logic [3:0] c, input int n);
    reset      = 1'b1;
    code_valid = cv;
    code       = c;
    repeat (n) @(posedge master_clk);
    #1;
    reset      = 1'b0;
    code_valid = 1'b0;
    phase      = 0;
    sb.delete();
    cur_dir    = 3'b100;
    push_dir   = 3'b100;
    cur_shoot  = 1'b0;
    ovf_e      = 1'b0;
`ifdef KEY_DEDUP_EN
    last_v     = 1'b0;
`endif
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_direction", direction, 3'b100);
    chk("rst_shoot", shoot, 0);
    chk("rst_tick", tick, 0);
  endtask

  task automatic step(input logic cv, input logic [3:0] c);
    logic tk, pop_e, dup_e, push_e, drop_e;
    exp_t e;
    code_valid = cv;
    code       = c;
    tk         = (phase == TICK_DIV - 1);
    chk("tick", tick, tk);
    pop_e = tk && (sb.size() > 0);
    dup_e = 1'b0;
`ifdef KEY_DEDUP_EN
    dup_e = cv && last_v && (c == last_c) && !tk;
`endif
    push_e = cv && !dup_e && ((sb.size() < DEPTH) || pop_e);
    drop_e = cv && !dup_e && (sb.size() == DEPTH) && !pop_e;
    @(posedge master_clk);
    #1;
    code_valid = 1'b0;
    phase = (phase + 1) % TICK_DIV;
    if (pop_e) begin
      e = sb.pop_front();
      cur_dir   = e.dir;
      cur_shoot = e.shoot;
    end else if (tk) begin
      cur_shoot = 1'b0;
    end
    if (push_e) begin
      e = decode(c, push_dir);
      push_dir = e.dir;
      sb.push_back(e);
    end
`ifdef KEY_DEDUP_EN
    if (tk) begin
      last_v = push_e;
      last_c = c;
    end else if (push_e) begin
      last_v = 1'b1;
      last_c = c;
    end
`endif
    if (drop_e) ovf_e = 1'b1;
    chk("direction", direction, cur_dir);
    chk("shoot", shoot, cur_shoot);
    chk("count", count, sb.size());
    chk("overflow", overflow, ovf_e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'h0);
  endtask

  initial begin
    int sh;
    reset      = 1'b1;
    code_valid = 1'b0;
    code       = 4'h0;

    // reset wins over a simultaneous code_valid
    do_reset(1'b1, 4'h4, 2);

    // idle: ticks on cycles 4, 8, 12 only
    idle(12);

    // left then right
    step(1'b1, 4'h4);
    step(1'b1, 4'h6);
    chk("req027_count", count, 2);
    idle(2);
    chk("req027_left", direction, 3'b001);
    idle(4);
    chk("req027_right", direction, 3'b010);
    chk("req027_empty", count, 0);
    idle(4);

    // shoot held for exactly one tick period
    step(1'b1, 4'h5);
    idle(3);
    chk("req028_dir", direction, 3'b100);
    sh = int'(shoot);
    repeat (4) begin
      step(1'b0, 4'h0);
      sh += int'(shoot);
    end
    chk("req028_shoot_len", sh, 4);
    idle(4);

    // fill, overflow, accept push on a full tick
    step(1'b1, 4'h4);
    step(1'b1, 4'h6);
    step(1'b1, 4'h4);
    step(1'b1, 4'h2);
    step(1'b1, 4'h9);
    chk("req029_full", count, 4);
    step(1'b1, 4'h7);
    chk("req029_overflow", overflow, 1);
    chk("req029_drop_count", count, 4);
    idle(1);
    step(1'b1, 4'h5);
    chk("req029_tick_push", count, 4);
    idle(16);
    chk("req029_drained", count, 0);
    chk("req029_sticky", overflow, 1);

    // repeated code within one tick period
    do_reset(1'b1, 4'h6, 1);
    step(1'b1, 4'h6);
    step(1'b1, 4'h6);
    step(1'b1, 4'h6);
`ifdef KEY_DEDUP_EN
    chk("req030_count", count, 1);
`else
    chk("req030_count", count, 3);
`endif
    chk("req030_overflow", overflow, 0);
    idle(16);

    // mid-operation reset discards queued codes
    step(1'b1, 4'h4);
    step(1'b1, 4'h2);
    step(1'b1, 4'h5);
    chk("req031_pre", count, 3);
    do_reset(1'b0, 4'h0, 1);
    idle(12);
    chk("req031_dir", direction, 3'b100);
    chk("req031_count", count, 0);
    chk("req031_shoot", shoot, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
